fft8_in_reorder: RTL and testbench
==================================

Name: fft8_in_reorder

Overview:
- Upstream input stage of the 8-point FFT datapath.
- Accepts complex samples one per cycle in natural time order over a valid/ready stream and collects them into frames of N_POINTS.
- Presents each completed frame in parallel, in bit-reversed order, so the first butterfly rank can consume it directly.
- Ping-pong buffered: one bank fills while the other is held for the consumer, giving sustained throughput of 1 sample/cycle.

Parameters:
- DATA_WIDTH, 16, width of each real and imaginary component, signed two's complement.
- N_POINTS, 8, frame length. Must be a power of 2, minimum 2. LOG2N is derived internally.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst_n  input  1  Reset, synchronous, active-low.
- in_valid  input  1  in_real/in_imag carry a sample.
- in_ready  output  1  Block can accept a sample this cycle.
- in_real  input  DATA_WIDTH  Sample real part, signed.
- in_imag  input  DATA_WIDTH  Sample imaginary part, signed.
- out_valid  output  1  A full reordered frame is presented.
- out_ready  input  1  Consumer takes the frame this cycle.
- out_real  output  N_POINTS*DATA_WIDTH  Slot k at [k*DATA_WIDTH +: DATA_WIDTH]; real part of sample bitrev(k).
- out_imag  output  N_POINTS*DATA_WIDTH  Same slot layout for imaginary parts.

Behaviour:
- Storage: two banks (0/1) of N_POINTS complex registers. Per-bank flag bank_full. Pointers wr_bank and rd_bank. Sample counter wr_cnt, LOG2N bits.
- Reset (rst_n=0 at a clock edge): wr_cnt=0, wr_bank=0, rd_bank=0, both bank_full=0. Outputs: in_ready=1, out_valid=0. Bank contents are not reset; out_real/out_imag are don't-care while out_valid=0.
- in_ready = !bank_full[wr_bank]. Purely combinational; no dependence on in_valid.
- Accept occurs when in_valid && in_ready. The sample is written to bank wr_bank at address bitrev(wr_cnt), then wr_cnt increments.
- Last sample of a frame (accept with wr_cnt == N_POINTS-1):
  - wr_cnt wraps to 0.
  - bank_full[wr_bank] is set.
  - wr_bank toggles.
- out_valid = bank_full[rd_bank]. out_real/out_imag are driven straight from bank rd_bank, with no output register.
- Latency: out_valid is high in the cycle immediately after the edge that accepted the last sample of the frame.
- Drain occurs when out_valid && out_ready: bank_full[rd_bank] is cleared and rd_bank toggles.
  - Out data must stay stable while out_valid=1 && out_ready=0.
- Simultaneous last-sample accept and drain: the two always target different banks, so both take effect in the same cycle. No bubble.
- Both banks full: in_ready=0 until a drain. After the drain edge, in_ready=1 with wr_bank pointing at the freed bank.
- in_valid while in_ready=0: the sample is ignored and wr_cnt holds. The producer must hold it.
- Reset mid-frame: the partial frame and any held frames are discarded. The next accepted sample is index 0 of a new frame.
- Bit reversal for N=8: slot order 0,4,2,6,1,5,3,7.
- No arithmetic in the default build; values pass through bit-exact.

Optional Feature:
- Macro: FFT_IN_PRESCALE_EN.
- Defined: each component is arithmetic-shifted right by LOG2N before being stored (sign-extended, truncation toward minus infinity). This gives the downstream butterflies LOG2N bits of growth headroom without overflow. The write path gains no extra cycle and latency is unchanged.
- Undefined: no shift; samples are stored bit-exact.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> in_ready=1, out_valid=0, and both stay so with in_valid=0.
- Single frame: in_real=1..8 and in_imag=0 on consecutive cycles, out_ready=1 -> out_valid=1 the cycle after sample 8 for exactly 1 cycle; out_real slots 0..7 = 1,5,3,7,2,6,4,8; all out_imag=0.
- Back-pressure: out_ready=0, offer 17 samples continuously.
  - in_ready must drop after the 16th accept and the 17th must stall.
  - Raise out_ready: frame A (samples 1-8) drains first, then frame B, and the 17th is accepted on the cycle after A drains.
- Streaming: 4 frames back to back at 1 sample/cycle with out_ready=1 -> in_ready never drops; out_valid pulses every 8 cycles; the data of each frame is correct.
- Reset mid-frame: accept 5 samples, pulse rst_n=0, then send 8 samples 0x10..0x17 -> exactly one frame, containing only the new values in bit-reversed order.
- Extremes: in_real=0x8000 and in_imag=0x7FFF in every slot, default build -> values output unchanged.
- With FFT_IN_PRESCALE_EN defined:
  - inputs -8, 7, -1 give -1, 0, -1;
  - 0x8000 gives 0xF000.

Source files
------------

// File: rtl/fft8_in_reorder.sv
// Input reorder stage for the 8-point FFT: collects natural-order samples into
// ping-pong banks at bit-reversed addresses. Optional macro: FFT_IN_PRESCALE_EN.
module fft8_in_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_real,
    input  logic [DATA_WIDTH-1:0]          in_imag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_real,
    output logic [N_POINTS*DATA_WIDTH-1:0] out_imag
);
    localparam int LOG2N = $clog2(N_POINTS);

    logic signed [DATA_WIDTH-1:0] re_q [2][N_POINTS];
    logic signed [DATA_WIDTH-1:0] re_d [2][N_POINTS];
    logic signed [DATA_WIDTH-1:0] im_q [2][N_POINTS];
    logic signed [DATA_WIDTH-1:0] im_d [2][N_POINTS];

    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             accept, drain, last;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

    // Arithmetic shift floors toward minus infinity, giving butterfly headroom.
    function automatic logic signed [DATA_WIDTH-1:0] prescale(input logic signed [DATA_WIDTH-1:0] x);
`ifdef FFT_IN_PRESCALE_EN
        return x >>> LOG2N;
`else
        return x;
`endif
    endfunction

    assign in_ready  = !bank_full_q[wr_bank_q];
    assign out_valid = bank_full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last      = (wr_cnt_q == LOG2N'(N_POINTS - 1));

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        bank_full_d = bank_full_q;
        re_d        = re_q;
        im_d        = im_q;
        if (accept) begin
            re_d[wr_bank_q][bitrev(wr_cnt_q)] = prescale($signed(in_real));
            im_d[wr_bank_q][bitrev(wr_cnt_q)] = prescale($signed(in_imag));
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (last) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = !wr_bank_q;
            end
        end
        // A completing fill and a drain always address different banks.
        if (drain) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= 2'b00;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            bank_full_q <= bank_full_d;
        end
    end

    always_ff @(posedge clk) begin
        re_q <= re_d;
        im_q <= im_d;
    end

    for (genvar k = 0; k < N_POINTS; k++) begin : g_slot
        assign out_real[k*DATA_WIDTH +: DATA_WIDTH] = re_q[rd_bank_q][k];
        assign out_imag[k*DATA_WIDTH +: DATA_WIDTH] = im_q[rd_bank_q][k];
    end

endmodule

// File: tb/tb_fft8_in_reorder.sv
// Scoreboard bench for fft8_in_reorder: a frame-level model predicts handshake
// state and the bit-reversed frame contents.
module tb_fft8_in_reorder;
    localparam int DW = 16;
    localparam int N  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_real, in_imag;
    logic          out_valid;
    logic          out_ready;
    logic [N*DW-1:0] out_real, out_imag;

    fft8_in_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int drained = 0;
    bit model_ok = 1'b0;
    bit rnd_done;

    logic [DW-1:0]   smp_re[$], smp_im[$];
    logic [N*DW-1:0] exp_re[$], exp_im[$];

    task automatic chk(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int rev(input int x);
        int r = 0;
        for (int b = 1; b < N; b = b * 2) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] raw);
        int v;
        v = $signed(raw);
`ifdef FFT_IN_PRESCALE_EN
        begin
            int q;
            q = v / N;
            if (v < 0 && (v % N) != 0) q = q - 1;
            v = q;
        end
`endif
        return DW'(v);
    endfunction

    // Monitor: check handshake against held-frame count, then predict the next edge.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("in_ready", N*DW'(in_ready), N*DW'(exp_re.size() < 2));
            chk("out_valid", N*DW'(out_valid), N*DW'(exp_re.size() > 0));
        end
        if (!rst_n) begin
            smp_re.delete(); smp_im.delete();
            exp_re.delete(); exp_im.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (out_valid && out_ready) begin
                if (exp_re.size() == 0) begin
                    chk("unexpected_frame", N*DW'(1), N*DW'(0));
                end else begin
                    chk("frame_real", out_real, exp_re.pop_front());
                    chk("frame_imag", out_imag, exp_im.pop_front());
                end
                drained++;
            end
            if (in_valid && in_ready) begin
                smp_re.push_back(scale(in_real));
                smp_im.push_back(scale(in_imag));
                if (smp_re.size() == N) begin
                    logic [N*DW-1:0] fr, fi;
                    for (int k = 0; k < N; k++) begin
                        fr[k*DW +: DW] = smp_re[rev(k)];
                        fi[k*DW +: DW] = smp_im[rev(k)];
                    end
                    exp_re.push_back(fr);
                    exp_im.push_back(fi);
                    smp_re.delete(); smp_im.delete();
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        bit acc;
        int cnt;
        in_valid = 1'b1; in_real = re; in_imag = im;
        cnt = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            cnt++;
        end while (!acc && cnt < 200);
        if (!acc) chk("send_timeout", N*DW'(0), N*DW'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_real = '0; in_imag = '0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        // Single frame 1..8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(DW'(i), '0);
        cyc(3);

        // Back-pressure: 17 offered with consumer stalled, then released
        out_ready = 1'b0;
        fork
            for (int i = 1; i <= 17; i++) send(DW'(i), DW'(i + 100));
            begin cyc(25); out_ready = 1'b1; end
        join
        for (int i = 18; i <= 24; i++) send(DW'(i), DW'(i + 100));
        cyc(4);

        // Streaming, four frames back to back
        out_ready = 1'b1;
        for (int i = 0; i < 4 * N; i++) send(DW'($urandom), DW'($urandom));
        cyc(4);

        // Reset mid-frame
        for (int i = 0; i < 5; i++) send(DW'(i + 40), DW'(i));
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        drained = 0;
        for (int i = 0; i < 8; i++) send(DW'(16'h10 + i), DW'(i));
        cyc(4);
        chk("frames_after_reset", N*DW'(drained), N*DW'(1));

        // Extremes
        for (int i = 0; i < 8; i++) send(16'h8000, 16'h7fff);
        // Rounding corner values
        send(16'hfff8, 16'h0007); send(16'h0007, 16'hffff); send(16'hffff, 16'hfff8);
        send(16'h8000, 16'h8000); send(16'h7fff, 16'h0001); send(16'h0008, 16'hfff9);
        send(16'hfff9, 16'h0000); send(16'h0000, 16'h7ff8);
        cyc(4);

        // Randomized gaps and consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    cyc($urandom_range(0, 2));
                    send(DW'($urandom), DW'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    cyc(1);
                end
            end
        join
        out_ready = 1'b1;
        cyc(6);
        chk("all_frames_drained", N*DW'(exp_re.size()), N*DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
